// File: rtl/fir_cfg_master_if.sv
// Command, response and AXI-Lite (AW/W/AR/R, no B) signal bundle for fir_cfg_master.
// The master modport is the view of the command engine itself; slave is the
// view of whoever issues commands and answers the bus.
interface fir_cfg_master_if #(
   parameter int unsigned pADDR_WIDTH = 12,
   parameter int unsigned pDATA_WIDTH = 32
) ();

   // Command channel
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [1:0]             cmd_op;
   logic [pADDR_WIDTH-1:0] cmd_addr;
   logic [pDATA_WIDTH-1:0] cmd_wdata;
   logic [pDATA_WIDTH-1:0] cmd_mask;

   // Response channel
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [pDATA_WIDTH-1:0] rsp_data;
   logic                   rsp_err;

   // AXI-Lite initiator
   logic                   awvalid;
   logic [pADDR_WIDTH-1:0] awaddr;
   logic                   awready;
   logic                   wvalid;
   logic [pDATA_WIDTH-1:0] wdata;
   logic                   wready;
   logic                   arvalid;
   logic [pADDR_WIDTH-1:0] araddr;
   logic                   arready;
   logic                   rvalid;
   logic [pDATA_WIDTH-1:0] rdata;
   logic                   rready;

   modport master (
      input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask,
      output cmd_ready,
      output rsp_valid, rsp_data, rsp_err,
      input  rsp_ready,
      output awvalid, awaddr,
      input  awready,
      output wvalid, wdata,
      input  wready,
      output arvalid, araddr,
      input  arready,
      input  rvalid, rdata,
      output rready
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask,
      input  cmd_ready,
      input  rsp_valid, rsp_data, rsp_err,
      output rsp_ready,
      input  awvalid, awaddr,
      output awready,
      input  wvalid, wdata,
      output wready,
      input  arvalid, araddr,
      output arready,
      output rvalid, rdata,
      input  rready
   );

endinterface

// File: rtl/fir_cfg_master.sv
// Command-driven AXI-Lite configuration master: single writes, single reads and
// masked poll loops with a bounded read count. One command in flight at a time;
// every bus and response output comes straight from a register.
module fir_cfg_master #(
   parameter int unsigned pADDR_WIDTH = 12,
   parameter int unsigned pDATA_WIDTH = 32,
   parameter int unsigned pPOLL_MAX   = 1024
) (
   input  logic              axis_clk,
   input  logic              axis_rst,
   fir_cfg_master_if.master  bus
);

   typedef enum logic [2:0] {
      StIdle,
      StWr,
      StRdA,
      StRdD,
      StGap,
      StRsp
   } state_t;

   state_t                 r_state;
   logic                   r_poll;
   logic [pADDR_WIDTH-1:0] r_addr;
   logic [pDATA_WIDTH-1:0] r_wdata;
   logic [pDATA_WIDTH-1:0] r_mask;
   logic [15:0]            r_poll_cnt;
   logic                   r_cmd_ready;
   logic                   r_awvalid;
   logic                   r_wvalid;
   logic                   r_arvalid;
   logic                   r_rready;
   logic                   r_rsp_valid;
   logic [pDATA_WIDTH-1:0] r_rsp_data;
   logic                   r_rsp_err;

   logic                   w_accept;
   logic                   w_aw_done;
   logic                   w_w_done;
   logic                   w_ar_ok;
   logic                   w_match;
   logic [15:0]            w_cnt_next;
   logic                   w_poll_limit;
   logic                   w_rd_to_gap;

   assign w_accept     = bus.cmd_valid & r_cmd_ready;
   // A channel counts as done if it was already done or handshakes this cycle.
   assign w_aw_done    = ~r_awvalid | bus.awready;
   assign w_w_done     = ~r_wvalid | bus.wready;
   // Read data is only taken once the address phase has finished (or finishes now).
   assign w_ar_ok      = (r_state == StRdD) | bus.arready;
   assign w_match      = ((bus.rdata ^ r_wdata) & r_mask) == '0;
   assign w_cnt_next   = r_poll_cnt + 16'd1;
   assign w_poll_limit = w_cnt_next >= 16'(pPOLL_MAX);
   assign w_rd_to_gap  = r_poll & ~w_match & ~w_poll_limit;

   assign bus.cmd_ready = r_cmd_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_data  = r_rsp_data;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.awvalid   = r_awvalid;
   assign bus.awaddr    = r_addr;
   assign bus.wvalid    = r_wvalid;
   assign bus.wdata     = r_wdata;
   assign bus.arvalid   = r_arvalid;
   assign bus.araddr    = r_addr;
   assign bus.rready    = r_rready;

   // Command FSM with all outputs registered.
   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         r_state     <= StIdle;
         r_poll      <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_mask      <= '0;
         r_poll_cnt  <= '0;
         r_cmd_ready <= 1'b0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               r_cmd_ready <= 1'b1;
               if (w_accept) begin
                  r_cmd_ready <= 1'b0;
                  r_addr      <= bus.cmd_addr;
                  r_wdata     <= bus.cmd_wdata;
                  r_mask      <= bus.cmd_mask;
                  r_poll_cnt  <= '0;
                  r_poll      <= (bus.cmd_op == 2'b10);
                  case (bus.cmd_op)
                     2'b00: begin
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= StWr;
                     end
                     2'b01, 2'b10: begin
                        r_arvalid <= 1'b1;
                        r_rready  <= 1'b1;
                        r_state   <= StRdA;
                     end
                     default: begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= StRsp;
                     end
                  endcase
               end
            end
            StWr: begin
               if (bus.awready) r_awvalid <= 1'b0;
               if (bus.wready)  r_wvalid  <= 1'b0;
               if (w_aw_done && w_w_done) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= '0;
                  r_rsp_err   <= 1'b0;
                  r_state     <= StRsp;
               end
            end
            StRdA, StRdD: begin
               if (r_state == StRdA && bus.arready) begin
                  r_arvalid <= 1'b0;
                  r_state   <= StRdD;
               end
               if (w_ar_ok && bus.rvalid) begin
                  r_rready   <= 1'b0;
                  r_poll_cnt <= w_cnt_next;
                  if (w_rd_to_gap) begin
                     r_state <= StGap;
                  end else begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_data  <= bus.rdata;
                     r_rsp_err   <= r_poll & ~w_match;
                     r_state     <= StRsp;
                  end
               end
            end
            StGap: begin
               r_arvalid <= 1'b1;
               r_rready  <= 1'b1;
               r_state   <= StRdA;
            end
            StRsp: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_cfg_master.sv
// Directed bench for fir_cfg_master: a table of commands with responder timing and
// hand-computed results, plus reset-at-start and reset-during-read sequences.
module tb_fir_cfg_master;

   logic axis_clk;
   logic axis_rst;

   fir_cfg_master_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) bus ();

   fir_cfg_master #(
      .pADDR_WIDTH(12),
      .pDATA_WIDTH(32),
      .pPOLL_MAX  (8)
   ) u_dut (
      .axis_clk(axis_clk),
      .axis_rst(axis_rst),
      .bus     (bus)
   );

   initial axis_clk = 1'b0;
   always #5 axis_clk = ~axis_clk;

   typedef struct {
      logic [1:0]  op;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] mask;
      int          aw_dly;
      int          w_dly;
      int          ar_dly;
      int          r_dly;
      int          miss_n;
      logic [31:0] miss_val;
      logic [31:0] hit_val;
      logic [31:0] exp_data;
      logic        exp_err;
      int          exp_aw;
      int          exp_w;
      int          exp_ar;
      int          exp_aw_only;
      int          exp_w_only;
   } vec_t;

   int   checks;
   int   errors;
   vec_t cur;
   vec_t vecs [9];

   // Responder / monitor statistics, cleared before each command.
   int n_aw, n_w, n_ar, rd_idx;
   int n_aw_only, n_w_only, addr_bad, gap_bad, seen_rsp;
   int cyc, fall_cyc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   // AW responder
   initial begin : aw_resp
      int cnt;
      cnt = 0;
      bus.awready = 1'b0;
      forever begin
         @(negedge axis_clk);
         bus.awready = 1'b0;
         if (bus.awvalid === 1'b1) begin
            if (cnt >= cur.aw_dly) begin
               bus.awready = 1'b1;
               cnt = 0;
               n_aw++;
            end else cnt++;
         end else cnt = 0;
      end
   end

   // W responder
   initial begin : w_resp
      int cnt;
      cnt = 0;
      bus.wready = 1'b0;
      forever begin
         @(negedge axis_clk);
         bus.wready = 1'b0;
         if (bus.wvalid === 1'b1) begin
            if (cnt >= cur.w_dly) begin
               bus.wready = 1'b1;
               cnt = 0;
               n_w++;
            end else cnt++;
         end else cnt = 0;
      end
   end

   // AR/R responder: one-cycle rvalid r_dly cycles after the arready cycle.
   initial begin : ar_resp
      int ar_cnt;
      int r_cnt;
      bit r_pend;
      ar_cnt = 0;
      r_cnt  = 0;
      r_pend = 1'b0;
      bus.arready = 1'b0;
      bus.rvalid  = 1'b0;
      bus.rdata   = '0;
      forever begin
         @(negedge axis_clk);
         bus.arready = 1'b0;
         bus.rvalid  = 1'b0;
         if (r_pend) begin
            if (r_cnt >= cur.r_dly) begin
               bus.rvalid = 1'b1;
               bus.rdata  = (rd_idx < cur.miss_n) ? cur.miss_val : cur.hit_val;
               rd_idx++;
               r_pend = 1'b0;
            end else r_cnt++;
         end else if (bus.arvalid === 1'b1) begin
            if (ar_cnt >= cur.ar_dly) begin
               bus.arready = 1'b1;
               ar_cnt = 0;
               n_ar++;
               if (cur.r_dly == 0) begin
                  bus.rvalid = 1'b1;
                  bus.rdata  = (rd_idx < cur.miss_n) ? cur.miss_val : cur.hit_val;
                  rd_idx++;
               end else begin
                  r_pend = 1'b1;
                  r_cnt  = 1;
               end
            end else ar_cnt++;
         end else ar_cnt = 0;
      end
   end

   // Bus monitor on DUT outputs only.
   initial begin : monitor
      logic prev_rready;
      logic prev_arvalid;
      prev_rready  = 1'b0;
      prev_arvalid = 1'b0;
      cyc          = 0;
      forever begin
         @(negedge axis_clk);
         cyc++;
         if (bus.awvalid === 1'b1 && bus.wvalid !== 1'b1) n_aw_only++;
         if (bus.wvalid === 1'b1 && bus.awvalid !== 1'b1) n_w_only++;
         if (bus.awvalid === 1'b1 && bus.awaddr !== cur.addr)  addr_bad++;
         if (bus.wvalid === 1'b1 && bus.wdata !== cur.wdata)   addr_bad++;
         if (bus.arvalid === 1'b1 && bus.araddr !== cur.addr)  addr_bad++;
         if (prev_rready === 1'b1 && bus.rready === 1'b0) fall_cyc = cyc;
         if (prev_arvalid !== 1'b1 && bus.arvalid === 1'b1 && fall_cyc >= 0 &&
             (cyc - fall_cyc) != 1) gap_bad++;
         if (bus.rsp_valid === 1'b1) seen_rsp++;
         prev_rready  = bus.rready;
         prev_arvalid = bus.arvalid;
      end
   end

   task automatic clear_stats();
      n_aw      = 0;
      n_w       = 0;
      n_ar      = 0;
      rd_idx    = 0;
      n_aw_only = 0;
      n_w_only  = 0;
      addr_bad  = 0;
      gap_bad   = 0;
      fall_cyc  = -1;
   endtask

   // Issue one command at a negedge with cmd_ready already checked high.
   task automatic issue(input vec_t v, input string nm);
      int t;
      t = 0;
      while (bus.cmd_ready !== 1'b1 && t < 50) begin
         @(negedge axis_clk);
         t++;
      end
      chk({nm, " cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
      bus.cmd_op    = v.op;
      bus.cmd_addr  = v.addr;
      bus.cmd_wdata = v.wdata;
      bus.cmd_mask  = v.mask;
      bus.cmd_valid = 1'b1;
      @(negedge axis_clk);
      bus.cmd_valid = 1'b0;
      // Scramble the command bus so only latched values can reach the AXI side.
      bus.cmd_addr  = ~v.addr;
      bus.cmd_wdata = ~v.wdata;
      bus.cmd_mask  = ~v.mask;
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int          t;
      int          unstable;
      logic [31:0] d0;
      logic        e0;
      cur = v;
      clear_stats();
      issue(v, nm);
      t = 0;
      while (bus.rsp_valid !== 1'b1 && t < 300) begin
         @(negedge axis_clk);
         t++;
      end
      chk({nm, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({nm, " rsp_data"}, bus.rsp_data, v.exp_data);
      chk({nm, " rsp_err"}, 32'(bus.rsp_err), 32'(v.exp_err));
      d0 = bus.rsp_data;
      e0 = bus.rsp_err;
      unstable = 0;
      repeat (2) begin
         @(negedge axis_clk);
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d0 || bus.rsp_err !== e0 ||
             bus.cmd_ready !== 1'b0) unstable++;
      end
      chk({nm, " rsp stable"}, 32'(unstable), 32'd0);
      bus.rsp_ready = 1'b1;
      @(negedge axis_clk);
      bus.rsp_ready = 1'b0;
      chk({nm, " rsp dropped"}, 32'({bus.rsp_valid, bus.cmd_ready}), 32'b01);
      chk({nm, " aw beats"}, 32'(n_aw), 32'(v.exp_aw));
      chk({nm, " w beats"}, 32'(n_w), 32'(v.exp_w));
      chk({nm, " ar beats"}, 32'(n_ar), 32'(v.exp_ar));
      chk({nm, " aw-only cycles"}, 32'(n_aw_only), 32'(v.exp_aw_only));
      chk({nm, " w-only cycles"}, 32'(n_w_only), 32'(v.exp_w_only));
      chk({nm, " gap length"}, 32'(gap_bad), 32'd0);
      chk({nm, " held addr/data"}, 32'(addr_bad), 32'd0);
   endtask

   initial begin : main
      vec_t rv;
      checks = 0;
      errors = 0;
      // op addr wdata mask | aw w ar r dly | miss_n miss hit | data err | aw w ar | aw_only w_only
      vecs[0] = '{2'd0, 12'h020, 32'hFFFF_FFF6, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0,
                  32'h0, 1'b0, 1, 1, 0, 0, 0};
      vecs[1] = '{2'd0, 12'h010, 32'd600, 32'h0, 0, 3, 0, 0, 0, 32'h0, 32'h0,
                  32'h0, 1'b0, 1, 1, 0, 0, 3};
      vecs[2] = '{2'd1, 12'h028, 32'h0, 32'h0, 0, 0, 2, 1, 0, 32'h0, 32'h17,
                  32'h17, 1'b0, 0, 0, 1, 0, 0};
      vecs[3] = '{2'd2, 12'h000, 32'h2, 32'h2, 0, 0, 0, 1, 4, 32'h4, 32'h6,
                  32'h6, 1'b0, 0, 0, 5, 0, 0};
      vecs[4] = '{2'd2, 12'h004, 32'h55, 32'hFF, 0, 0, 1, 0, 100, 32'h54, 32'h55,
                  32'h54, 1'b1, 0, 0, 8, 0, 0};
      vecs[5] = '{2'd3, 12'h030, 32'h1, 32'h1, 0, 0, 0, 0, 0, 32'h0, 32'h0,
                  32'h0, 1'b1, 0, 0, 0, 0, 0};
      vecs[6] = '{2'd1, 12'h03C, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'hDEAD_BEEF,
                  32'hDEAD_BEEF, 1'b0, 0, 0, 1, 0, 0};
      vecs[7] = '{2'd0, 12'h008, 32'h1234_5678, 32'h0, 2, 0, 0, 0, 0, 32'h0, 32'h0,
                  32'h0, 1'b0, 1, 1, 0, 2, 0};
      vecs[8] = '{2'd2, 12'h00C, 32'hA5, 32'hF0, 0, 0, 0, 2, 0, 32'h0, 32'hAF,
                  32'hAF, 1'b0, 0, 0, 1, 0, 0};

      cur           = vecs[0];
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'd0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.cmd_mask  = '0;
      bus.rsp_ready = 1'b0;
      axis_rst      = 1'b1;
      clear_stats();
      repeat (3) @(negedge axis_clk);
      chk("reset outputs", 32'({bus.awvalid, bus.wvalid, bus.arvalid, bus.rready,
                                bus.rsp_valid, bus.rsp_err, bus.cmd_ready}), 32'd0);
      chk("reset rsp_data", bus.rsp_data, 32'd0);
      axis_rst = 1'b0;
      @(negedge axis_clk);
      chk("ready after reset", 32'(bus.cmd_ready), 32'd1);

      for (int i = 0; i < 9; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset while waiting for read data: abandon with no response.
      rv = '{2'd1, 12'h014, 32'h0, 32'h0, 0, 0, 0, 6, 0, 32'h0, 32'h99,
             32'h99, 1'b0, 0, 0, 1, 0, 0};
      cur = rv;
      clear_stats();
      issue(rv, "mid_rst");
      @(negedge axis_clk);
      chk("mid_rst in RD_D", 32'({bus.arvalid, bus.rready}), 32'b01);
      axis_rst = 1'b1;
      @(negedge axis_clk);
      axis_rst = 1'b0;
      chk("mid_rst outputs", 32'({bus.awvalid, bus.wvalid, bus.arvalid, bus.rready,
                                  bus.rsp_valid, bus.cmd_ready}), 32'd0);
      seen_rsp = 0;
      @(negedge axis_clk);
      chk("mid_rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
      repeat (10) @(negedge axis_clk);
      chk("mid_rst no rsp", 32'(seen_rsp), 32'd0);
      rv = '{2'd1, 12'h018, 32'h0, 32'h0, 0, 0, 1, 1, 0, 32'h0, 32'h0BAD_F00D,
             32'h0BAD_F00D, 1'b0, 0, 0, 1, 0, 0};
      run_vec(rv, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fir_cfg_master.md
FIR_CFG_MASTER -- requirements
Module: fir_cfg_master

Interface
REQ-001 SHALL have parameter pADDR_WIDTH, default 12, AXI-Lite address width.
REQ-002 SHALL have parameter pDATA_WIDTH, default 32, AXI-Lite data width.
REQ-003 SHALL have parameter pPOLL_MAX, default 1024, maximum reads per poll command (1..65535).
REQ-004 SHALL use one clock and a synchronous, active-high reset:
- axis_clk  in  1  sole clock; all logic on rising edge.
- axis_rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have the command ports:
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when both high.
- cmd_op  in  2  00 write, 01 read, 10 poll, 11 illegal.
- cmd_addr  in  pADDR_WIDTH  target register address.
- cmd_wdata  in  pDATA_WIDTH  write data, or poll expected value.
- cmd_mask  in  pDATA_WIDTH  poll compare mask.
REQ-006 SHALL have the response ports:
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_data  out  pDATA_WIDTH  read data, or last poll read; 0 for writes.
- rsp_err  out  1  poll timeout or illegal op.
REQ-007 SHALL have the AXI-Lite initiator ports (no B channel):
- awvalid  out  1
- awaddr  out  pADDR_WIDTH
- awready  in  1
- wvalid  out  1
- wdata  out  pDATA_WIDTH
- wready  in  1
- arvalid  out  1
- araddr  out  pADDR_WIDTH
- arready  in  1
- rvalid  in  1
- rdata  in  pDATA_WIDTH
- rready  out  1

Function
REQ-008 SHALL implement states IDLE, WR, RD_A, RD_D, GAP, RSP.
REQ-009 SHALL drive cmd_ready=1 only in IDLE; cmd_addr, cmd_wdata and cmd_mask SHALL be latched on the accepting edge.
REQ-010 Write: awvalid and wvalid SHALL rise together in the cycle after accept.
- Each SHALL drop independently on the edge of its own handshake.
- Both handshakes complete (same or different cycles) -> RSP with rsp_data=0 and rsp_err=0.
REQ-011 Read/poll: arvalid and rready SHALL rise in the cycle after accept.
- arvalid SHALL drop on the arready handshake.
- rready SHALL stay high until the rvalid handshake; rdata is captured on that edge.
- rvalid arriving in the same cycle as arready SHALL be accepted.
REQ-012 Read: after capture -> RSP with rsp_data=captured rdata and rsp_err=0.
REQ-013 Poll match, i.e. (rdata & mask) == (expected & mask): SHALL go to RSP with rsp_data=rdata and rsp_err=0.
REQ-014 Poll mismatch: SHALL spend exactly 1 cycle in GAP with arvalid=0, then reissue the same araddr.
- A 16-bit read counter SHALL increment per completed read.
- If the count reaches pPOLL_MAX -> RSP with rsp_data=last rdata and rsp_err=1.
REQ-015 Illegal op 11: SHALL go directly to RSP with rsp_err=1 and rsp_data=0; no bus activity.
REQ-016 rsp_valid SHALL be high only in RSP, with rsp_data and rsp_err stable.
- RSP -> IDLE on the rsp_ready handshake.
- No new command is accepted in the handshake cycle.
REQ-017 awaddr, wdata and araddr SHALL hold the latched values for the whole transaction.
- ready inputs arriving while the matching valid is low SHALL be ignored.
REQ-018 Commands SHALL be processed strictly in order, one outstanding at a time.

Reset
REQ-019 While axis_rst=1 at a clock edge, the following SHALL be 0 after that edge: awvalid, wvalid, arvalid, rready, rsp_valid, rsp_err, rsp_data, cmd_ready.
- State SHALL go to IDLE and the poll counter SHALL clear.
REQ-020 Reset asserted mid-transaction SHALL abandon the transaction with no response; cmd_ready=1 the first cycle after reset deasserts.

Verification
REQ-021 Write 0x20 data 0xFFFFFFF6, awready and wready both immediate -> one aw/w beat, then rsp_valid with rsp_err=0.
REQ-022 Write 0x10 data 600, wready 3 cycles after awready -> awvalid drops first, wvalid held until wready, then one response.
REQ-023 Read 0x28, arready 2-cycle stall, rvalid 1 cycle later with 0x17 -> rsp_data=0x17, rsp_err=0.
REQ-024 Poll 0x00, mask 0x2, expected 0x2, responder returns 0x4 four times then 0x6 -> 5 reads with a 1-cycle gap between each, rsp_data=0x6, rsp_err=0.
REQ-025 Poll with pPOLL_MAX=8 and no match -> exactly 8 reads, rsp_err=1; then op 11 -> rsp_err=1 with no arvalid/awvalid.
REQ-026 axis_rst pulsed during RD_D -> all valids 0 next cycle, no rsp_valid, next command executes normally.
